sprite_line_scheduler: RTL and testbench
========================================

# sprite_line_scheduler

Per-scanline sprite scheduler for the sprite layer. It runs once per line. It scans the 2 KB sprite RAM (512 four-byte entries), tests each sprite's vertical position against the line being prepared, and hands hit sprites one at a time to the line-buffer draw engine through a valid/ready handshake. It also generates the line-buffer A/B swap and reports per-line overflow. It replaces the fixed PROM-sequenced latch/counter chain with an explicit FSM in the `master_clk` domain.

## Interface
Parameters:
- `MAX_PER_LINE`, default 32: sprites issued per line before the scan stops with overflow.
- `NUM_SPR`, default 512: entries scanned (entry n occupies bytes 4n..4n+3).

Ports:
- `master_clk`  in  1  sole clock. All logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `line_start`  in  1  one-cycle pulse at the start of each line's horizontal blank.
- `next_line`  in  8  vertical line number to prepare; sampled on `line_start`.
- `flip`  in  1  screen flip; sampled on `line_start`.
- `spr_addr`  out  11  sprite RAM read address.
- `spr_data`  in  8  sprite RAM data, valid the cycle after `spr_addr`.
- `desc_valid`  out  1  descriptor available.
- `desc_ready`  in  1  draw engine accepts the descriptor.
- `desc_code`  out  10  tile code.
- `desc_hpos`  out  9  start X.
- `desc_color`  out  4  palette select.
- `desc_row`  out  4  row within the 16-line sprite.
- `line_swap`  out  1  one-cycle pulse: toggle which line buffer is written and which is displayed.
- `busy`  out  1  scan in progress.
- `overflow`  out  1  previous line exceeded `MAX_PER_LINE` or was aborted. Updated on `line_start`.

## Operation
- Entry layout:
  - byte0: code[7:0]
  - byte1: hpos[7:0]
  - byte2: bit0 hpos[8], bits4:1 color, bits7:6 code[9:8]
  - byte3: vpos
- States: IDLE, RD_V, CHK, RD_C, RD_H, RD_X, ISSUE.
- IDLE: on `line_start`:
  - latch `next_line` and `flip`
  - clear the entry index and issue count
  - pulse `line_swap`
  - go to RD_V
- RD_V: drive `spr_addr` = 4·idx+3, then go to CHK.
- CHK: compute diff = (line − spr_data) mod 256.
  - Hit iff diff < 16. Row = diff[3:0].
  - Hit: go to RD_C.
  - Miss: increment idx and go to RD_V, or go to IDLE if idx = NUM_SPR−1.
- RD_C, RD_H, RD_X: read bytes 0, 1, 2. Each byte is captured into the descriptor register one cycle after its address is driven.
- ISSUE: assert `desc_valid` and hold all `desc_*` stable until `desc_ready`.
  - On accept: increment the count.
  - If count = MAX_PER_LINE: set `ovf_pend` and go to IDLE.
  - Otherwise advance idx as in CHK.
- Arithmetic: diff is 8-bit wrap-around. vpos=250 with line=3 gives diff=9, which is a hit with row 9. The entry index wraps at NUM_SPR and ends the scan.
- Reset: state IDLE and all outputs 0. This includes `desc_valid`, `line_swap`, `busy`, `overflow`, and `spr_addr`=0.

## Timing
- `line_start` to first `spr_addr`: 1 cycle. `busy` rises with RD_V.
- Cost per entry, assuming `desc_ready` is high:
  - miss: 2 cycles
  - hit: 6 cycles (RD_V, CHK, RD_C, RD_H, RD_X, ISSUE)
- `desc_valid` may rise only in ISSUE. It never drops without a handshake, except on abort or reset.
- `line_start` while the FSM is not in IDLE aborts the scan:
  - `desc_valid` drops in the same cycle
  - set `ovf_pend`
  - immediately restart for the new line, including a `line_swap` pulse
- `overflow` <= `ovf_pend` on every `line_start`, then `ovf_pend` clears.
- `reset` coincident with `line_start`: `reset` wins. No swap pulse.

## Configuration
- `SPR_SCHED_FLIP_EN` defined:
  - when latched `flip` = 1, `desc_row` = 15 − diff[3:0]
  - `desc_hpos` = 9'd495 − hpos (mirrored within a 512 span, accounting for the 16-pixel width)
- Not defined: `flip` is ignored, and row/hpos pass through unmodified.

## Structure
- Shared package `slap_spr_pkg`:
  - state enum
  - byte offsets (OFS_CODE=0, OFS_HPOS=1, OFS_XDAT=2, OFS_VPOS=3)
  - SPR_HEIGHT=16
  - descriptor struct (code, hpos, color, row)
- Sub-module `spr_desc_reg`: the byte capture/unpack register, including the flip transform.

## Test plan
- Single hit: entry 0 vpos=0x20, code=0x155, hpos=0x1A3, color=5; `next_line`=0x25, `desc_ready`=1 → one descriptor: code 0x155, hpos 0x1A3, color 5, row 5. `line_swap` asserted one cycle after `line_start`.
- Wrap: vpos=0xFA, line=0x03 → hit, row 9. vpos=0x10, line=0x0F → miss in 2 cycles.
- Backpressure: hold `desc_ready`=0 for 10 cycles → `desc_valid` held and `desc_*` stable; the scan continues on release.
- Overflow: 40 sprites all hitting, MAX_PER_LINE=32 → exactly 32 descriptors; `overflow`=1 after the next `line_start`, then 0 on the following line if clean.
- Abort: `line_start` at entry 100 with `desc_valid`=1 → `desc_valid` drops the same cycle, the scan restarts at entry 0, and `overflow`=1 is reported at the next `line_start`.
- Flip (macro on, `flip`=1): diff=3, hpos=0x010 → row 12, hpos 0x1DF.

Source files
------------

// File: rtl/slap_spr_pkg.sv
// Shared types and constants for the sprite layer scheduler.
// Entry layout in sprite RAM (4 bytes per sprite):
//   byte0 code[7:0] | byte1 hpos[7:0] | byte2 {code[9:8], -, color, hpos[8]} | byte3 vpos
package slap_spr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_V,
    CHK,
    RD_C,
    RD_H,
    RD_X,
    ISSUE
  } state_t;

  localparam logic [1:0] OFS_CODE = 2'd0;
  localparam logic [1:0] OFS_HPOS = 2'd1;
  localparam logic [1:0] OFS_XDAT = 2'd2;
  localparam logic [1:0] OFS_VPOS = 2'd3;

  localparam int SPR_HEIGHT = 16;

  // Entry index width: 11-bit byte address, 4 bytes per entry.
  localparam int IDX_W = 9;

  typedef struct packed {
    logic [9:0] code;
    logic [8:0] hpos;
    logic [3:0] color;
    logic [3:0] row;
  } desc_t;

  // Vertical distance from the sprite top to the line, wrapping at 256.
  function automatic logic [7:0] line_diff(input logic [7:0] line, input logic [7:0] vpos);
    return line - vpos;
  endfunction

endpackage

// File: rtl/spr_desc_reg.sv
// Descriptor capture register: collects the row and the three data bytes of a
// hit sprite and unpacks them into a descriptor.
// Optional feature macro: SPR_SCHED_FLIP_EN (screen-flip mirroring of row/hpos).
module spr_desc_reg
  import slap_spr_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flip,
  input  logic       cap_row,
  input  logic [3:0] row_in,
  input  logic       cap_code,
  input  logic       cap_hpos,
  input  logic       cap_xdat,
  input  logic [7:0] data,
  output desc_t      desc
);

  desc_t raw;

  // Capture each field in the cycle its byte is on the RAM data bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw <= '0;
    end else begin
      if (cap_row)  raw.row        <= row_in;
      if (cap_code) raw.code[7:0]  <= data;
      if (cap_hpos) raw.hpos[7:0]  <= data;
      if (cap_xdat) begin
        raw.hpos[8]   <= data[0];
        raw.color     <= data[4:1];
        raw.code[9:8] <= data[7:6];
      end
    end
  end

`ifdef SPR_SCHED_FLIP_EN
  // Mirror row and X position when the screen is flipped; output stays a pure
  // function of held registers, so it is stable while the descriptor waits.
  always_comb begin
    desc = raw;
    if (flip) begin
      desc.row  = 4'(SPR_HEIGHT - 1) - raw.row;
      desc.hpos = 9'(512 - SPR_HEIGHT - 1) - raw.hpos;
    end
  end
`else
  logic unused_flip;
  assign unused_flip = flip;

  // Without flip support the captured fields pass straight through.
  always_comb begin
    desc = raw;
  end
`endif

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans sprite RAM once per line, hands hit
// sprites to the draw engine over valid/ready, pulses the line-buffer swap and
// reports per-line overflow/abort.
// Optional feature macro: SPR_SCHED_FLIP_EN (handled in spr_desc_reg).
module sprite_line_scheduler
  import slap_spr_pkg::*;
#(
  parameter int MAX_PER_LINE = 32,
  parameter int NUM_SPR      = 512
) (
  input  logic        master_clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  next_line,
  input  logic        flip,
  output logic [10:0] spr_addr,
  input  logic [7:0]  spr_data,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic [9:0]  desc_code,
  output logic [8:0]  desc_hpos,
  output logic [3:0]  desc_color,
  output logic [3:0]  desc_row,
  output logic        line_swap,
  output logic        busy,
  output logic        overflow
);

  localparam int              CNT_W    = $clog2(MAX_PER_LINE + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPR - 1);

  state_t           state, state_nx;
  logic [7:0]       line_q;
  logic             flip_q;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             ovf_pend;
  logic [7:0]       diff;
  logic             hit;
  logic             last_idx;
  logic             accept;
  logic             at_max;
  desc_t            desc;

  // Hit test and handshake decode.
  always_comb begin
    diff       = line_diff(line_q, spr_data);
    hit        = diff < 8'(SPR_HEIGHT);
    last_idx   = idx == LAST_IDX;
    // An aborting line_start withdraws the descriptor in the same cycle.
    desc_valid = (state == ISSUE) && !line_start;
    accept     = desc_valid && desc_ready;
    count_inc  = count + 1'b1;
    at_max     = count_inc == CNT_W'(MAX_PER_LINE);
    busy       = state != IDLE;
  end

  // Next-state logic; line_start from any state (re)starts the scan.
  always_comb begin
    // NOTE: assign every combinational output a default first so no path leaves it unassigned (no latch).
    state_nx = state;
    if (line_start) begin
      state_nx = RD_V;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        RD_V:    state_nx = CHK;
        CHK:     state_nx = hit ? RD_C : (last_idx ? IDLE : RD_V);
        RD_C:    state_nx = RD_H;
        RD_H:    state_nx = RD_X;
        RD_X:    state_nx = ISSUE;
        ISSUE: begin
          if (accept) state_nx = (at_max || last_idx) ? IDLE : RD_V;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // RAM address: the next byte is requested one state ahead of its capture.
  always_comb begin
    spr_addr = '0;
    case (state)
      RD_V:    spr_addr = {idx, OFS_VPOS};
      CHK:     spr_addr = {idx, OFS_CODE};
      RD_C:    spr_addr = {idx, OFS_HPOS};
      RD_H:    spr_addr = {idx, OFS_XDAT};
      default: spr_addr = '0;
    endcase
  end

  // State register, per-line context, counters and overflow tracking.
  always_ff @(posedge master_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= IDLE;
      line_q    <= '0;
      flip_q    <= 1'b0;
      idx       <= '0;
      count     <= '0;
      ovf_pend  <= 1'b0;
      overflow  <= 1'b0;
      line_swap <= 1'b0;
    end else begin
      state     <= state_nx;
      line_swap <= line_start;
      if (line_start) begin
        line_q   <= next_line;
        flip_q   <= flip;
        idx      <= '0;
        count    <= '0;
        overflow <= ovf_pend;
        // A line_start mid-scan aborts the line being prepared.
        ovf_pend <= state != IDLE;
      end else begin
        if (state == CHK && !hit) idx <= idx + 1'b1;
        if (accept) begin
          count <= count_inc;
          idx   <= idx + 1'b1;
          if (at_max) ovf_pend <= 1'b1;
        end
      end
    end
  end

  spr_desc_reg u_desc_reg (
    .clk      (master_clk),
    .reset    (reset),
    .flip     (flip_q),
    .cap_row  (state == CHK && hit),
    .row_in   (diff[3:0]),
    .cap_code (state == RD_C),
    .cap_hpos (state == RD_H),
    .cap_xdat (state == RD_X),
    .data     (spr_data),
    .desc     (desc)
  );

  assign desc_code  = desc.code;
  assign desc_hpos  = desc.hpos;
  assign desc_color = desc.color;
  assign desc_row   = desc.row;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler with a synchronous sprite RAM model.
module tb_sprite_line_scheduler;
  import slap_spr_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [7:0]  next_line;
  logic        flip;
  logic [10:0] spr_addr;
  logic [7:0]  spr_data;
  logic        desc_valid;
  logic        desc_ready;
  logic [9:0]  desc_code;
  logic [8:0]  desc_hpos;
  logic [3:0]  desc_color;
  logic [3:0]  desc_row;
  logic        line_swap;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:2047];
  desc_t      got [$];
  desc_t      mon_d;

`ifdef SPR_SCHED_FLIP_EN
  localparam logic [3:0] FLIP_ROW  = 4'd12;
  localparam logic [8:0] FLIP_HPOS = 9'h1DF;
`else
  localparam logic [3:0] FLIP_ROW  = 4'd3;
  localparam logic [8:0] FLIP_HPOS = 9'h010;
`endif

  sprite_line_scheduler dut (
    .master_clk (clk),
    .reset      (reset),
    .line_start (line_start),
    .next_line  (next_line),
    .flip       (flip),
    .spr_addr   (spr_addr),
    .spr_data   (spr_data),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_code  (desc_code),
    .desc_hpos  (desc_hpos),
    .desc_color (desc_color),
    .desc_row   (desc_row),
    .line_swap  (line_swap),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) spr_data <= mem[spr_addr];

  // Record every descriptor handshake that will complete on the next edge.
  always @(negedge clk) begin
    if (desc_valid === 1'b1 && desc_ready === 1'b1) begin
      mon_d.code  = desc_code;
      mon_d.hpos  = desc_hpos;
      mon_d.color = desc_color;
      mon_d.row   = desc_row;
      got.push_back(mon_d);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int n, input logic [9:0] code, input logic [8:0] hpos,
                           input logic [3:0] color, input logic [7:0] vpos);
    mem[4*n]   = code[7:0];
    mem[4*n+1] = hpos[7:0];
    mem[4*n+2] = {code[9:8], 1'b0, color, hpos[8]};
    mem[4*n+3] = vpos;
  endtask

  task automatic pulse_line(input logic [7:0] l, input logic f);
    @(posedge clk); #1;
    line_start = 1'b1; next_line = l; flip = f;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (desc_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(desc_valid), 32'd1);
  endtask

  initial begin
    reset = 1'b1; line_start = 1'b0; next_line = '0; flip = 1'b0; desc_ready = 1'b1;
    for (int n = 0; n < 512; n++) set_entry(n, 10'h0, 9'h0, 4'h0, 8'h80);
    set_entry(0, 10'h155, 9'h1A3, 4'd5, 8'h20);

    // Reset with a coincident line_start: reset wins, no swap.
    @(posedge clk); #1;
    line_start = 1'b1; next_line = 8'h25;
    @(posedge clk); #1;
    line_start = 1'b0;
    @(negedge clk);
    check("rst_swap",     32'(line_swap),  32'd0);
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_valid",    32'(desc_valid), 32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    check("rst_addr",     32'(spr_addr),   32'd0);
    check("rst_code",     32'(desc_code),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single hit: timing of swap, first address and descriptor.
    got.delete();
    pulse_line(8'h25, 1'b0);
    @(negedge clk);
    check("hit_swap",  32'(line_swap), 32'd1);
    check("hit_busy",  32'(busy),      32'd1);
    check("hit_addr0", 32'(spr_addr),  32'd3);
    repeat (4) @(negedge clk);
    check("hit_valid_early", 32'(desc_valid), 32'd0);
    @(negedge clk);
    check("hit_valid", 32'(desc_valid), 32'd1);
    check("hit_code",  32'(desc_code),  32'h155);
    check("hit_hpos",  32'(desc_hpos),  32'h1A3);
    check("hit_color", 32'(desc_color), 32'd5);
    check("hit_row",   32'(desc_row),   32'd5);
    wait_idle("hit_idle", 3000);
    check("hit_count", 32'(got.size()), 32'd1);
    check("hit_ovf",   32'(overflow),   32'd0);

    // Vertical wrap-around: vpos 0xFA on line 3 is row 9.
    set_entry(0, 10'h0AA, 9'h055, 4'hA, 8'hFA);
    got.delete();
    pulse_line(8'h03, 1'b0);
    wait_idle("wrap_idle", 3000);
    check("wrap_count", 32'(got.size()), 32'd1);
    check("wrap_row",   32'(got[0].row),  32'd9);
    check("wrap_code",  32'(got[0].code), 32'h0AA);
    check("wrap_color", 32'(got[0].color), 32'hA);

    // Miss costs 2 cycles; window edges diff=15 (hit) and diff=16 (miss).
    set_entry(0, 10'h000, 9'h000, 4'h0, 8'h10);
    set_entry(1, 10'h201, 9'h0FF, 4'hF, 8'h0F);
    set_entry(2, 10'h111, 9'h011, 4'h1, 8'hFF);
    set_entry(3, 10'h3FF, 9'h100, 4'h0, 8'h00);
    got.delete();
    pulse_line(8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    check("miss_next_addr", 32'(spr_addr), 32'd7);
    wait_idle("edge_idle", 3000);
    check("edge_count", 32'(got.size()),  32'd2);
    check("edge_row0",  32'(got[0].row),  32'd0);
    check("edge_code0", 32'(got[0].code), 32'h201);
    check("edge_row15", 32'(got[1].row),  32'd15);
    check("edge_hpos1", 32'(got[1].hpos), 32'h100);

    // Backpressure: descriptor held stable for 10 cycles, scan resumes.
    desc_ready = 1'b0;
    got.delete();
    pulse_line(8'h0F, 1'b0);
    wait_valid("bp_valid", 100);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", 32'(desc_valid), 32'd1);
      check("bp_hold_desc",  32'({desc_code, desc_hpos, desc_color, desc_row}),
            32'({10'h201, 9'h0FF, 4'hF, 4'h0}));
      @(negedge clk);
    end
    desc_ready = 1'b1;
    wait_idle("bp_idle", 3000);
    check("bp_count", 32'(got.size()),  32'd2);
    check("bp_first", 32'(got[0].code), 32'h201);
    check("bp_last",  32'(got[1].row),  32'd15);

    // Overflow: 40 hits, only MAX_PER_LINE issued, reported on next line.
    for (int n = 0; n < 40; n++) set_entry(n, 10'(n), 9'(n), 4'(n), 8'h40);
    got.delete();
    pulse_line(8'h40, 1'b0);
    wait_idle("ovf_idle", 400);
    check("ovf_count",   32'(got.size()),   32'd32);
    check("ovf_last",    32'(got[31].code), 32'd31);
    check("ovf_not_yet", 32'(overflow),     32'd0);
    got.delete();
    pulse_line(8'h50, 1'b0);
    @(negedge clk);
    check("ovf_report", 32'(overflow), 32'd1);
    wait_idle("clean_idle", 3000);
    check("clean_count", 32'(got.size()), 32'd0);
    pulse_line(8'h50, 1'b0);
    @(negedge clk);
    check("ovf_cleared", 32'(overflow), 32'd0);
    wait_idle("clean_idle2", 3000);

    // Abort: line_start while entry 100 waits in ISSUE.
    set_entry(100, 10'h3C5, 9'h123, 4'd3, 8'h60);
    desc_ready = 1'b0;
    got.delete();
    pulse_line(8'h60, 1'b0);
    wait_valid("abort_reach", 1000);
    @(posedge clk); #1;
    line_start = 1'b1; next_line = 8'h60;
    @(negedge clk);
    check("abort_drop", 32'(desc_valid), 32'd0);
    @(posedge clk); #1;
    line_start = 1'b0;
    @(negedge clk);
    check("abort_swap",    32'(line_swap), 32'd1);
    check("abort_restart", 32'(spr_addr),  32'd3);
    check("abort_ovf_old", 32'(overflow),  32'd0);
    desc_ready = 1'b1;
    wait_idle("abort_idle", 3000);
    check("abort_count", 32'(got.size()),  32'd1);
    check("abort_code",  32'(got[0].code), 32'h3C5);
    pulse_line(8'h50, 1'b0);
    @(negedge clk);
    check("abort_report", 32'(overflow), 32'd1);
    wait_idle("abort_idle2", 3000);

    // Flip: diff=3, hpos=0x010 (mirrored only when the feature is built in).
    set_entry(100, 10'h0, 9'h0, 4'h0, 8'h80);
    set_entry(5, 10'h2AB, 9'h010, 4'hC, 8'h70);
    got.delete();
    pulse_line(8'h73, 1'b1);
    wait_idle("flip_idle", 3000);
    check("flip_count", 32'(got.size()),   32'd1);
    check("flip_row",   32'(got[0].row),   32'(FLIP_ROW));
    check("flip_hpos",  32'(got[0].hpos),  32'(FLIP_HPOS));
    check("flip_code",  32'(got[0].code),  32'h2AB);
    got.delete();
    pulse_line(8'h73, 1'b0);
    wait_idle("noflip_idle", 3000);
    check("noflip_row",  32'(got[0].row),  32'd3);
    check("noflip_hpos", 32'(got[0].hpos), 32'h010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
